mem_wb_stage: RTL and testbench

MEM/WB pipeline register with an integrated writeback selector. It replaces the flat two-input memtoreg select. It captures MEM-stage results on the clock edge and extracts and extends load data by access size and address lane. It then selects among four writeback sources, supports stall and flush, suppresses x0 writes and counts retired instructions. It sits between the data-memory stage and the register file and drives the WB forwarding path.

---
 rtl/mem_wb_stage.sv | 147 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Brief    : MEM/WB pipeline register with load extraction, 4-way writeback
//            select, stall/flush, x0 write suppression and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         mem_valid,
  input  logic [REG_AW-1:0]            mem_rd,
  input  logic                         mem_regwrite,
  input  logic [1:0]                   mem_wb_sel,
  input  logic [2:0]                   mem_funct3,
  input  logic [$clog2(XLEN/8)-1:0]    mem_addr_lo,
  input  logic [XLEN-1:0]              mem_alu_result,
  input  logic [XLEN-1:0]              mem_pc_plus4,
  input  logic [XLEN-1:0]              mem_imm,
  input  logic [XLEN-1:0]              mem_read_data,
  output logic                         wb_valid,
  output logic [REG_AW-1:0]            wb_rd,
  output logic                         wb_we,
  output logic [XLEN-1:0]              wb_data,
  output logic [CNT_W-1:0]             retired_count
);

  localparam int                    c_lane_w    = $clog2(XLEN/8);
  // Half lane ignores bit 0; word lane keeps only bits above bit 1.
  localparam logic [c_lane_w-1:0]   c_half_mask = ~(c_lane_w'(1));
  localparam logic [c_lane_w-1:0]   c_word_mask = ~(c_lane_w'(3));

  localparam logic [1:0] c_sel_alu  = 2'b00;
  localparam logic [1:0] c_sel_load = 2'b01;
  localparam logic [1:0] c_sel_pc4  = 2'b10;

  logic                  r_valid;
  logic [REG_AW-1:0]     r_rd;
  logic                  r_regwrite;
  logic [1:0]            r_wb_sel;
  logic [2:0]            r_funct3;
  logic [c_lane_w-1:0]   r_addr_lo;
  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [XLEN-1:0]       r_imm;
  logic [XLEN-1:0]       r_read_data;
  logic [CNT_W-1:0]      r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_wb_sel     <= '0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_alu_result <= '0;
      r_pc_plus4   <= '0;
      r_imm        <= '0;
      r_read_data  <= '0;
      r_count      <= '0;
    end else begin
      // An instruction leaving WB retires, including when a flush displaces it.
      if (r_valid && (flush || !stall)) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (flush) begin
        r_valid      <= 1'b0;
        r_rd         <= '0;
        r_regwrite   <= 1'b0;
        r_wb_sel     <= '0;
        r_funct3     <= '0;
        r_addr_lo    <= '0;
        r_alu_result <= '0;
        r_pc_plus4   <= '0;
        r_imm        <= '0;
        r_read_data  <= '0;
      end else if (!stall) begin
        r_valid      <= mem_valid;
        r_rd         <= mem_rd;
        r_regwrite   <= mem_regwrite;
        r_wb_sel     <= mem_wb_sel;
        r_funct3     <= mem_funct3;
        r_addr_lo    <= mem_addr_lo;
        r_alu_result <= mem_alu_result;
        r_pc_plus4   <= mem_pc_plus4;
        r_imm        <= mem_imm;
        r_read_data  <= mem_read_data;
      end
    end
  end

  logic [c_lane_w+2:0] w_byte_sh;
  logic [c_lane_w+2:0] w_half_sh;
  logic [c_lane_w+2:0] w_word_sh;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_word;
  logic [XLEN-1:0]     w_load;

  assign w_byte_sh = {r_addr_lo, 3'b000};
  assign w_half_sh = {r_addr_lo & c_half_mask, 3'b000};
  assign w_word_sh = {r_addr_lo & c_word_mask, 3'b000};
  assign w_byte    = 8'(r_read_data >> w_byte_sh);
  assign w_half    = 16'(r_read_data >> w_half_sh);
  assign w_word    = 32'(r_read_data >> w_word_sh);

  always_comb begin
    w_load = r_read_data;
    case (r_funct3)
      3'b000: w_load = XLEN'($signed(w_byte));
      3'b001: w_load = XLEN'($signed(w_half));
      3'b010: w_load = XLEN'($signed(w_word));
      3'b100: w_load = XLEN'(w_byte);
      3'b101: w_load = XLEN'(w_half);
      3'b110: if (XLEN == 64) w_load = XLEN'(w_word);
      default: w_load = r_read_data;
    endcase
  end

  always_comb begin
    wb_data = '0;
    if (r_valid) begin
      case (r_wb_sel)
        c_sel_alu:  wb_data = r_alu_result;
        c_sel_load: wb_data = w_load;
        c_sel_pc4:  wb_data = r_pc_plus4;
        default:    wb_data = r_imm;
      endcase
    end
  end

  assign wb_valid      = r_valid;
  assign wb_rd         = r_rd;
  assign wb_we         = r_valid & r_regwrite & (r_rd != '0);
  assign retired_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Scoreboard bench for mem_wb_stage (XLEN=32, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result, mem_pc_plus4, mem_imm, mem_read_data;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  retired_count;

  mem_wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_imm(mem_imm), .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference WB register contents
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel, m_lo;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_pc4, m_imm, m_raw;
  logic [3:0]  m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [31:0] raw, logic [2:0] f3, logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    case (lo)
      2'd0: b = raw[7:0];
      2'd1: b = raw[15:8];
      2'd2: b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lo[1] ? raw[31:16] : raw[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return raw;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.valid = m_valid;
    e.rd    = m_rd;
    e.we    = m_valid & m_rw & (m_rd != 5'd0);
    e.cnt   = m_cnt;
    if (!m_valid)           e.data = 32'h0;
    else if (m_sel == 2'd0) e.data = m_alu;
    else if (m_sel == 2'd1) e.data = ref_load(m_raw, m_f3, m_lo);
    else if (m_sel == 2'd2) e.data = m_pc4;
    else                    e.data = m_imm;
    return e;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_lo = 0; m_f3 = 0;
    m_alu = 0; m_pc4 = 0; m_imm = 0; m_raw = 0;
  endtask

  // Advance the model by one edge, push the expectation, clock, then compare.
  task automatic tick(input string tag);
    exp_t e;
    if (rst) begin
      model_clear();
      m_cnt = 0;
    end else begin
      if (m_valid && (flush || !stall)) m_cnt = m_cnt + 4'd1;
      if (flush) model_clear();
      else if (!stall) begin
        m_valid = mem_valid; m_rw = mem_regwrite; m_rd = mem_rd; m_sel = mem_wb_sel;
        m_lo = mem_addr_lo; m_f3 = mem_funct3; m_alu = mem_alu_result;
        m_pc4 = mem_pc_plus4; m_imm = mem_imm; m_raw = mem_read_data;
      end
    end
    q.push_back(model_out());
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".valid"}, 64'(wb_valid), 64'(e.valid));
    chk({tag, ".rd"},    64'(wb_rd),    64'(e.rd));
    chk({tag, ".we"},    64'(wb_we),    64'(e.we));
    chk({tag, ".data"},  64'(wb_data),  64'(e.data));
    chk({tag, ".cnt"},   64'(retired_count), 64'(e.cnt));
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rd, input logic rw,
                           input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo);
    mem_valid = v; mem_rd = rd; mem_regwrite = rw;
    mem_wb_sel = sel; mem_funct3 = f3; mem_addr_lo = lo;
  endtask

  logic [3:0] cnt_a;

  initial begin
    rst = 1; stall = 0; flush = 0;
    set_instr(0, 0, 0, 0, 0, 0);
    mem_alu_result = 32'h1111_1111; mem_pc_plus4 = 32'h0000_0104;
    mem_imm = 32'hABCD_E000; mem_read_data = 32'h80F1_7F82;
    model_clear(); m_cnt = 0;
    tick("reset");
    chk("reset.cnt0", 64'(retired_count), 64'd0);
    rst = 0;

    // Reset mid-stream
    set_instr(1, 5'd3, 1, 2'd0, 3'd0, 2'd0);
    tick("fill0");
    tick("fill1");
    rst = 1;
    tick("rst_mid");
    chk("rst_mid.we", 64'(wb_we), 64'd0);
    chk("rst_mid.cnt", 64'(retired_count), 64'd0);
    rst = 0;

    // Load extraction
    set_instr(1, 5'd7, 1, 2'd1, 3'b000, 2'd0); tick("lb0");
    chk("lb0.lit", 64'(wb_data), 64'hFFFF_FF82);
    set_instr(1, 5'd7, 1, 2'd1, 3'b100, 2'd0); tick("lbu0");
    chk("lbu0.lit", 64'(wb_data), 64'h0000_0082);
    set_instr(1, 5'd7, 1, 2'd1, 3'b000, 2'd1); tick("lb1");
    chk("lb1.lit", 64'(wb_data), 64'h0000_007F);
    set_instr(1, 5'd7, 1, 2'd1, 3'b001, 2'd2); tick("lh2");
    chk("lh2.lit", 64'(wb_data), 64'hFFFF_80F1);
    set_instr(1, 5'd7, 1, 2'd1, 3'b101, 2'd2); tick("lhu2");
    chk("lhu2.lit", 64'(wb_data), 64'h0000_80F1);
    set_instr(1, 5'd7, 1, 2'd1, 3'b010, 2'd0); tick("lw");
    chk("lw.lit", 64'(wb_data), 64'h80F1_7F82);

    // Source select
    set_instr(1, 5'd9, 1, 2'd0, 3'd0, 2'd0); tick("sel_alu");
    chk("sel_alu.lit", 64'(wb_data), 64'h1111_1111);
    set_instr(1, 5'd9, 1, 2'd2, 3'd0, 2'd0); tick("sel_pc4");
    chk("sel_pc4.lit", 64'(wb_data), 64'h0000_0104);
    set_instr(1, 5'd9, 1, 2'd3, 3'd0, 2'd0); tick("sel_imm");
    chk("sel_imm.lit", 64'(wb_data), 64'hABCD_E000);
    set_instr(1, 5'd0, 1, 2'd0, 3'd0, 2'd0); tick("x0");
    chk("x0.we", 64'(wb_we), 64'd0);

    // Stall hold: A stays in WB for three stalled cycles and retires once
    set_instr(1, 5'd12, 1, 2'd0, 3'd0, 2'd0); mem_alu_result = 32'hAAAA_0001;
    tick("cap_a");
    cnt_a = retired_count;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 5'(20 + i), 1, 2'd3, 3'd0, 2'd0);
      mem_alu_result = 32'h5555_0000 + i;
      tick("stall");
      chk("stall.hold", 64'(wb_data), 64'hAAAA_0001);
      chk("stall.cnt", 64'(retired_count), 64'(cnt_a));
    end
    stall = 0;
    set_instr(1, 5'd13, 1, 2'd0, 3'd0, 2'd0);
    tick("unstall");
    chk("unstall.cnt", 64'(retired_count), 64'(cnt_a + 4'd1));

    // Flush and stall together
    flush = 1; stall = 1;
    tick("flush_stall");
    chk("flush.valid", 64'(wb_valid), 64'd0);
    chk("flush.data", 64'(wb_data), 64'd0);
    cnt_a = retired_count;
    flush = 0; stall = 0;
    set_instr(0, 5'd4, 1, 2'd0, 3'd0, 2'd0);
    tick("bubble");
    chk("bubble.cnt", 64'(retired_count), 64'(cnt_a));

    // Counter wrap: 17 retirements with a bubble mid-run
    rst = 1; tick("wrap_rst"); rst = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) set_instr(0, 5'd1, 1, 2'd0, 3'd0, 2'd0);
      else        set_instr(1, 5'd1, 1, 2'd0, 3'd0, 2'd0);
      tick("wrap");
    end
    set_instr(0, 5'd1, 1, 2'd0, 3'd0, 2'd0);
    tick("wrap_last");
    chk("wrap.end", 64'(retired_count), 64'd1);
    tick("wrap_idle");
    chk("wrap.idle", 64'(retired_count), 64'd1);

    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      set_instr(1'($urandom), 5'($urandom), 1'($urandom), 2'($urandom),
                3'($urandom), 2'($urandom));
      mem_alu_result = $urandom; mem_pc_plus4 = $urandom;
      mem_imm = $urandom; mem_read_data = $urandom;
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
